// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scanner: digit count,
// the active-low hex glyph set {g,f,e,d,c,b,a} and the all-off pattern.
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam int NIB_W  = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // All segments dark
    localparam logic [6:0] BLANK = 7'h7F;

    // Active-low one-hot anode pattern selecting a single digit
    function automatic logic [DIGITS-1:0] anode_mask(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for a common-anode seven-segment digit.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [6:0]       seg_o
);

    // Full 16-entry hex lookup; the default only guards against X propagation
    always_comb begin
        seg_o = BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner. A shadow register collects
// loads during a frame and is promoted to the displayed value only at the
// frame boundary, so a frame never shows a mix of two values. Each digit
// slot starts with an anode-off guard interval to suppress ghosting, and
// leading zeros can optionally be blanked.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int GUARD = 64
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);

    // Scan state
    logic [DIV_W-1:0] presc_q, presc_d;
    digit_idx_t       idx_q, idx_d;
    logic             blank_en_q, blank_en_d;

    // Double buffer
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      active_q, active_d;
    logic             pending_q, pending_d;

    // Registered outputs
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;

    // Decode helpers
    logic                        tc;
    logic                        boundary;
    logic [DIGITS-1:0][NIB_W-1:0] nibbles;
    logic [DIGITS-1:0]           upper_zero;
    logic [NIB_W-1:0]            cur_nibble;
    logic [6:0]                  glyph;
    logic                        digit_blank;
    logic                        in_guard;

    // Split the displayed value into digits and flag, per digit, whether it
    // and every more-significant digit are zero (leading-zero candidate)
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibbles[gi]    = active_q[NIB_W*gi +: NIB_W];
            assign upper_zero[gi] = (active_q[15 : NIB_W*gi] == '0);
        end
    endgenerate

    assign cur_nibble = nibbles[idx_q];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (cur_nibble),
        .seg_o    (glyph)
    );

    // Prescaler, digit index and double-buffer next-state logic
    always_comb begin
        tc         = &presc_q;
        boundary   = tc && (idx_q == 2'd3);

        presc_d    = presc_q + 1'b1;
        idx_d      = tc ? idx_q + 2'd1 : idx_q;
        // blank_lz is captured once per slot so a slot never half-blanks
        blank_en_d = tc ? blank_lz : blank_en_q;

        shadow_d   = shadow_q;
        active_d   = active_q;
        pending_d  = pending_q;

        if (boundary) begin
            // A load landing exactly on the boundary bypasses the shadow
            if (load) begin
                active_d = value;
                shadow_d = value;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            // Later loads in the same frame simply overwrite the shadow
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // Output pattern for the current prescaler/idx state, registered below
    always_comb begin
        digit_blank  = blank_en_q && (idx_q != 2'd0) && upper_zero[idx_q];
        in_guard     = (presc_q < GUARD_CNT);
        frame_done_d = boundary;

        if (digit_blank) begin
            // Blanking wins over the decimal point request
            seg_d  = BLANK;
            dp_n_d = 1'b1;
            an_d   = 4'hF;
        end else begin
            // During the guard the segments already carry the new digit
            seg_d  = glyph;
            dp_n_d = ~dp[idx_q];
            an_d   = in_guard ? 4'hF : anode_mask(idx_q);
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            blank_en_q   <= 1'b0;
            shadow_q     <= 16'h0000;
            active_q     <= 16'h0000;
            pending_q    <= 1'b0;
            seg_q        <= BLANK;
            dp_n_q       <= 1'b1;
            an_q         <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            blank_en_q   <= blank_en_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
